// File: rtl/guvm_wb_pkg.sv
// Shared types and limits for the Wishbone stimulus responder.
package guvm_wb_pkg;

    // Responder bus-side state machine
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } wb_state_e;

    // Legal configuration limits
    localparam int unsigned DATA_W_MIN  = 32;
    localparam int unsigned DATA_W_MAX  = 128;
    localparam int unsigned WAIT_ST_MAX = 7;
    localparam int unsigned WAIT_CNT_W  = 3;

    // Width of the 32-bit lane index inside a DATA_W bus word; a single-lane
    // bus still gets one (always-masked) bit so the index is never zero-width.
    function automatic int unsigned lane_sel_w(input int unsigned data_w);
        return (data_w > 32) ? $clog2(data_w / 32) : 1;
    endfunction

endpackage

// File: rtl/guvm_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored. Pointers wrap naturally because DEPTH is a power of two.
module guvm_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; contents are not reset, the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/guvm_wb_responder.sv
// Wishbone slave that answers core reads from a queue of pushed instruction
// words and captures core writes for inspection.
// Optional feature: define GUVM_WB_ERR_INJ_EN to add s_err, a per-entry flag
// that turns the matching read ack into a wb_err response.
module guvm_wb_responder
    import guvm_wb_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WAIT_ST = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [31:0]              s_data,
`ifdef GUVM_WB_ERR_INJ_EN
    input  logic                     s_err,
`endif
    output logic                     s_ready,
    input  logic [31:0]              wb_adr,
    input  logic [DATA_W/8-1:0]      wb_sel,
    input  logic                     wb_we,
    input  logic                     wb_cyc,
    input  logic                     wb_stb,
    input  logic [DATA_W-1:0]        wb_dat_o,
    output logic [DATA_W-1:0]        wb_dat_i,
    output logic                     wb_ack,
    output logic                     wb_err,
    output logic                     r_valid,
    output logic [31:0]              r_data,
    output logic [31:0]              r_adr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);

    localparam int unsigned LANES  = DATA_W / 32;
    localparam int unsigned LANE_W = lane_sel_w(DATA_W);
`ifdef GUVM_WB_ERR_INJ_EN
    localparam int unsigned FIFO_W = 33;
`else
    localparam int unsigned FIFO_W = 32;
`endif

    wb_state_e               state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic                    underrun_q, underrun_d;
    logic                    cap_en;
    logic [31:0]             r_data_q, r_adr_q;

    logic [FIFO_W-1:0]       fifo_wdata, fifo_rdata;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [31:0]             rd_word;
    logic                    rd_err;
    logic                    in_ack;

    logic [LANE_W-1:0]       lane_idx;
    logic [DATA_W-1:0]       dat_shift;
    logic [31:0]             wr_lane;

    // Byte selects carry no meaning for this responder
    logic                    unused_sel;
    assign unused_sel = ^wb_sel;

`ifdef GUVM_WB_ERR_INJ_EN
    assign fifo_wdata = {s_err, s_data};
    assign rd_err     = fifo_rdata[32];
`else
    assign fifo_wdata = s_data;
    assign rd_err     = 1'b0;
`endif
    assign rd_word = fifo_rdata[31:0];

    guvm_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign s_ready = !fifo_full;

    // Write lane chosen by the word-address bits inside one bus beat
    assign lane_idx  = wb_adr[LANE_W+1:2] & LANE_W'(LANES - 1);
    assign dat_shift = wb_dat_o >> {lane_idx, 5'd0};
    assign wr_lane   = dat_shift[31:0];

    // Next-state logic: wait-state count, read stall on empty, cyc abort
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        underrun_d = underrun_q;
        cap_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc && wb_stb) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    we_d    = wb_we;
                end
            end
            StWait: begin
                if (!wb_cyc) begin
                    state_d = StIdle;
                end else if (cnt_q != WAIT_CNT_W'(WAIT_ST)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (we_q) begin
                    state_d = StAck;
                    cap_en  = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = StAck;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            underrun_q <= 1'b0;
            r_data_q   <= '0;
            r_adr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            underrun_q <= underrun_d;
            if (cap_en) begin
                r_data_q <= wr_lane;
                r_adr_q  <= wb_adr;
            end
        end
    end

    // Response outputs decoded from the ACK state; the FIFO head is stable
    // throughout ACK because the pop lands on the edge that leaves it.
    always_comb begin
        in_ack   = (state_q == StAck);
        fifo_pop = in_ack && !we_q;
        wb_ack   = in_ack && (we_q || !rd_err);
        wb_dat_i = (fifo_pop && !rd_err) ? {LANES{rd_word}} : '0;
        r_valid  = in_ack && we_q;
    end

`ifdef GUVM_WB_ERR_INJ_EN
    assign wb_err = fifo_pop && rd_err;
`else
    assign wb_err = 1'b0;
`endif

    assign r_data   = r_data_q;
    assign r_adr    = r_adr_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_guvm_wb_responder.sv
// Scoreboard bench: bus tasks queue the expected response, an independent
// negedge monitor pops and compares whenever the responder acks or errors.
module tb_guvm_wb_responder;
    import guvm_wb_pkg::*;

    localparam int unsigned DW = 128;

    logic           clk = 1'b0;
    logic           rst_n, rst_n2;
    logic           s_valid, s_valid2;
    logic [31:0]    s_data;
`ifdef GUVM_WB_ERR_INJ_EN
    logic           s_err;
`endif
    logic           s_ready, s_ready2;
    logic [31:0]    wb_adr;
    logic [DW/8-1:0] wb_sel;
    logic           wb_we, wb_cyc, wb_stb, wb_cyc2, wb_stb2;
    logic [DW-1:0]  wb_dat_o;
    logic [DW-1:0]  wb_dat_i, wb_dat_i2;
    logic           wb_ack, wb_err, wb_ack2, wb_err2;
    logic           r_valid, r_valid2;
    logic [31:0]    r_data, r_adr, r_data2, r_adr2;
    logic [3:0]     level;
    logic [2:0]     level2;
    logic           underrun, underrun2;

    int total = 0;
    int bad = 0;
    int cycle_cnt = 0;
    int ack2_cnt = 0;
    logic prev_ack = 1'b0;

    typedef struct {
        int          cyc;
        logic        we;
        logic        err;
        logic [127:0] dat;
        logic [31:0] rdata;
        logic [31:0] radr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    guvm_wb_responder #(.DATA_W(DW), .DEPTH(8), .WAIT_ST(0)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
`ifdef GUVM_WB_ERR_INJ_EN
        .s_err    (s_err),
`endif
        .s_ready  (s_ready),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .r_valid  (r_valid),
        .r_data   (r_data),
        .r_adr    (r_adr),
        .level    (level),
        .underrun (underrun)
    );

    guvm_wb_responder #(.DATA_W(DW), .DEPTH(4), .WAIT_ST(3)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n2),
        .s_valid  (s_valid2),
        .s_data   (s_data),
`ifdef GUVM_WB_ERR_INJ_EN
        .s_err    (1'b0),
`endif
        .s_ready  (s_ready2),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_we    (1'b0),
        .wb_cyc   (wb_cyc2),
        .wb_stb   (wb_stb2),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i2),
        .wb_ack   (wb_ack2),
        .wb_err   (wb_err2),
        .r_valid  (r_valid2),
        .r_data   (r_data2),
        .r_adr    (r_adr2),
        .level    (level2),
        .underrun (underrun2)
    );

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    // Monitor: every ack/err must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_ack || wb_err) begin
                chk("ack_not_back_to_back", prev_ack, 1'b0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: ack=%0b err=%0b at cycle %0d, none expected",
                             wb_ack, wb_err, cycle_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_cycle", cycle_cnt, e.cyc);
                    chk("wb_ack", wb_ack, !e.err);
                    chk("wb_err", wb_err, e.err);
                    chk("wb_dat_i", wb_dat_i, e.dat);
                    chk("r_valid", r_valid, e.we);
                    if (e.we) begin
                        chk("r_data", r_data, e.rdata);
                        chk("r_adr", r_adr, e.radr);
                    end
                end
            end else begin
                chk("idle_dat_i", wb_dat_i, '0);
                chk("idle_r_valid", r_valid, 1'b0);
            end
            prev_ack = wb_ack || wb_err;
        end
    end

    always @(negedge clk) begin
        if (rst_n2 && wb_ack2) ack2_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1);
    end

    // All tasks start and end at #1 after a rising edge
    task automatic push_word(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

`ifdef GUVM_WB_ERR_INJ_EN
    task automatic push_err_word(input logic [31:0] d);
        s_err = 1'b1;
        push_word(d);
        s_err = 1'b0;
    endtask
`endif

    task automatic bus_start(input logic we, input logic [31:0] adr, input logic [127:0] dat);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = adr;
        wb_dat_o = dat;
        wb_sel   = '1;
    endtask

    task automatic bus_finish(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (wb_ack || wb_err) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: no response within 40 cycles, want one", name);
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] w, input logic e,
                      input string name);
        exp_t x;
        x.cyc   = cycle_cnt + 2;
        x.we    = 1'b0;
        x.err   = e;
        x.dat   = e ? 128'h0 : {4{w}};
        x.rdata = '0;
        x.radr  = '0;
        exp_q.push_back(x);
        bus_start(1'b0, adr, '0);
        bus_finish(name);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [127:0] dat, input logic [31:0] lane,
                      input string name);
        exp_t x;
        x.cyc   = cycle_cnt + 2;
        x.we    = 1'b1;
        x.err   = 1'b0;
        x.dat   = '0;
        x.rdata = lane;
        x.radr  = adr;
        exp_q.push_back(x);
        bus_start(1'b1, adr, dat);
        bus_finish(name);
    endtask

    initial begin
        exp_t x;
        int   c0;
        bit   got;

        rst_n = 1'b0; rst_n2 = 1'b0;
        s_valid = 1'b0; s_valid2 = 1'b0; s_data = '0;
`ifdef GUVM_WB_ERR_INJ_EN
        s_err = 1'b0;
`endif
        wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        wb_cyc2 = 1'b0; wb_stb2 = 1'b0; wb_dat_o = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 4'd0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_ack", wb_ack, 1'b0);
        chk("rst_err", wb_err, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_dat_i", wb_dat_i, '0);
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_r_adr", r_adr, 32'h0);
        rst_n = 1'b1; rst_n2 = 1'b1;
        @(posedge clk); #1;

        // Single read, zero wait states
        push_word(32'hE3A01005);
        chk("s1_level_before", level, 4'd1);
        rd(32'h0, 32'hE3A01005, 1'b0, "s1_read");
        chk("s1_level_after", level, 4'd0);

        // Read stalls on empty FIFO, flags underrun, acks after the push
        chk("s2_underrun_clear", underrun, 1'b0);
        bus_start(1'b0, 32'h0, '0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("s2_underrun_set", underrun, 1'b1);
        x.cyc = cycle_cnt + 2; x.we = 1'b0; x.err = 1'b0;
        x.dat = {4{32'hE0812002}}; x.rdata = '0; x.radr = '0;
        exp_q.push_back(x);
        push_word(32'hE0812002);
        bus_finish("s2_read");
        chk("s2_level_after", level, 4'd0);

        // Writes capture the addressed lane and leave the FIFO alone
        push_word(32'h11111111);
        wr(32'h8, 128'h00000000_0000002A_CAFEF00D_12345678, 32'h0000002A, "s3_write_lane2");
        chk("s3_level_kept", level, 4'd1);
        wr(32'h4, 128'h00000000_0000002A_CAFEF00D_12345678, 32'hCAFEF00D, "s3_write_lane1");
        rd(32'h0, 32'h11111111, 1'b0, "s3_read_back");

        // Push and pop in the same cycle keep level and order
        push_word(32'hAAAA0001);
        push_word(32'hAAAA0002);
        fork
            rd(32'h0, 32'hAAAA0001, 1'b0, "s4_read_a");
            begin
                @(posedge clk); @(posedge clk); #1;
                push_word(32'hAAAA0003);
            end
        join
        chk("s4_level_pushpop", level, 4'd2);
        rd(32'h0, 32'hAAAA0002, 1'b0, "s4_read_b");
        rd(32'h0, 32'hAAAA0003, 1'b0, "s4_read_c");

        // Fill to full, drop the overflow word, drain in order across the wrap
        for (int i = 0; i < 8; i++) push_word(32'hA0000000 + i);
        chk("s5_s_ready_full", s_ready, 1'b0);
        chk("s5_level_full", level, 4'd8);
        push_word(32'hBAD00009);
        chk("s5_level_dropped", level, 4'd8);
        for (int i = 0; i < 8; i++) rd(32'h10 + 4 * i, 32'hA0000000 + i, 1'b0, "s5_drain");
        chk("s5_level_empty", level, 4'd0);
        chk("s5_s_ready_empty", s_ready, 1'b1);

`ifdef GUVM_WB_ERR_INJ_EN
        // Error-tagged entry answers with wb_err and zero data
        push_err_word(32'h5555AAAA);
        push_word(32'h0000BEEF);
        rd(32'h0, 32'h5555AAAA, 1'b1, "s6_err_read");
        rd(32'h0, 32'h0000BEEF, 1'b0, "s6_ok_read");
        chk("s6_level", level, 4'd0);
`endif

        // WAIT_ST=3 instance: reset on the 2nd wait cycle aborts the read
        s_valid2 = 1'b1; s_data = 32'h77770001;
        @(posedge clk); #1;
        s_valid2 = 1'b0;
        chk("s7_level_loaded", level2, 3'd1);
        wb_adr = 32'h0; wb_cyc2 = 1'b1; wb_stb2 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n2 = 1'b0;
        #1;
        chk("s7_state_idle", u_dut2.state_q, StIdle);
        chk("s7_level_cleared", level2, 3'd0);
        chk("s7_ack", wb_ack2, 1'b0);
        chk("s7_underrun", underrun2, 1'b0);
        chk("s7_s_ready", s_ready2, 1'b1);
        chk("s7_dat_i", wb_dat_i2, '0);
        wb_cyc2 = 1'b0; wb_stb2 = 1'b0;
        @(posedge clk); #1;
        rst_n2 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("s7_no_ack_after_abort", ack2_cnt, 0);
        chk("s7_level_still_zero", level2, 3'd0);

        // WAIT_ST=3 read latency: ack three cycles later than the zero-wait case
        s_valid2 = 1'b1; s_data = 32'h77770002;
        @(posedge clk); #1;
        s_valid2 = 1'b0;
        c0 = cycle_cnt;
        wb_cyc2 = 1'b1; wb_stb2 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wb_ack2) got = 1'b1;
        end
        chk("s8_ack_seen", got, 1'b1);
        chk("s8_ack_cycle", cycle_cnt, c0 + 5);
        chk("s8_dat_i", wb_dat_i2, {4{32'h77770002}});
        chk("s8_err", wb_err2, 1'b0);
        chk("s8_r_valid", r_valid2, 1'b0);
        @(posedge clk); #1;
        wb_cyc2 = 1'b0; wb_stb2 = 1'b0;
        chk("s8_level_after", level2, 3'd0);
        chk("s8_r_data", r_data2, 32'h0);
        chk("s8_r_adr", r_adr2, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/guvm_wb_responder.md
GUVM_WB_RESPONDER -- requirements
Module: guvm_wb_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning core Wishbone data width; legal values 32, 64, 128.
REQ-002 SHALL have parameter DEPTH, default 8, meaning stimulus FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter WAIT_ST, default 0, meaning wait states inserted before each ack; legal range 0..7.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have ports:
  - clk  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
  - s_valid  in  1  stimulus word push
  - s_data  in  32  instruction word
  - s_ready  out  1  FIFO not full
  - wb_adr  in  32  core address
  - wb_sel  in  DATA_W/8  byte selects
  - wb_we  in  1  write enable
  - wb_cyc  in  1  cycle
  - wb_stb  in  1  strobe
  - wb_dat_o  in  DATA_W  core write data
  - wb_dat_i  out  DATA_W  read data to core
  - wb_ack  out  1  acknowledge
  - wb_err  out  1  error
  - r_valid  out  1  write captured
  - r_data  out  32  captured write lane
  - r_adr  out  32  captured write address
  - level  out  $clog2(DEPTH)+1  FIFO occupancy
  - underrun  out  1  sticky: read stalled on empty FIFO

Function
REQ-006 SHALL accept a push when s_valid and s_ready are both high at a rising edge.
REQ-007 SHALL drive s_ready as the inverse of FIFO full; a push while full SHALL be ignored.
REQ-008 SHALL implement FSM IDLE -> WAIT -> ACK -> IDLE.
  - IDLE -> WAIT when wb_cyc and wb_stb are high at an edge.
  - WAIT -> ACK after WAIT_ST further cycles; for reads, only once the FIFO is non-empty.
  - ACK -> IDLE unconditionally.
REQ-009 SHALL assert wb_ack for exactly one cycle, in state ACK.
  - For a read, the first ack cycle is N+1+WAIT_ST, where N is the sampling edge (FIFO non-empty).
  - Ack is never asserted in two consecutive cycles.
REQ-010 On a read ack, SHALL pop one FIFO entry and drive it replicated across all DATA_W/32 lanes of wb_dat_i; wb_dat_i SHALL be zero in all other cycles.
REQ-011 A read in WAIT with an empty FIFO SHALL set underrun (sticky until reset) and stall; ack SHALL come one cycle after the first push is accepted (WAIT_ST already elapsed).
REQ-012 On a write ack, the block SHALL:
  - capture the wb_dat_o lane selected by wb_adr[$clog2(DATA_W/8)-1:2] into r_data;
  - capture wb_adr into r_adr;
  - pulse r_valid for one cycle, coincident with wb_ack;
  - leave the FIFO unchanged.
REQ-013 A push and a pop in the same cycle SHALL leave level unchanged and preserve FIFO order.
REQ-014 Read/write pointers SHALL wrap modulo DEPTH.
REQ-015 wb_cyc deasserted during WAIT SHALL return the FSM to IDLE with no ack and no pop.

Reset
REQ-016 While rst_n is low, SHALL hold:
  - FSM = IDLE, pointers = 0, level = 0;
  - wb_ack, wb_err, r_valid, underrun = 0;
  - wb_dat_i, r_data, r_adr = 0;
  - s_ready = 1.
REQ-017 Reset asserted mid-transaction SHALL abort it with no ack and no pop, and FIFO contents SHALL be discarded.

Configuration
REQ-018 With GUVM_WB_ERR_INJ_EN defined, the block SHALL add input s_err (1 bit) stored with each FIFO entry.
  - A read popping an entry with s_err=1 SHALL pulse wb_err instead of wb_ack, with wb_dat_i zero.
REQ-019 Without GUVM_WB_ERR_INJ_EN, the s_err port SHALL be absent, wb_err SHALL be tied 0, and FIFO entries SHALL be 32 bits.

Structure
REQ-020 Package guvm_wb_pkg SHALL hold the FSM state enum, the lane-select width function, and the legal DATA_W/WAIT_ST limits.
REQ-021 The FIFO SHALL be sub-module guvm_sync_fifo (parameters WIDTH, DEPTH; outputs full, empty, level).

Verification
REQ-022 The bench SHALL cover these scenarios:
  - Push 0xE3A01005, read at adr 0x0, WAIT_ST=0 -> wb_ack on the next cycle, wb_dat_i={4{E3A01005}}, level 1->0.
  - Read on an empty FIFO for 5 cycles, then push 0xE0812002 -> no ack for 5 cycles, underrun=1, ack one cycle after the push, data 0xE0812002.
  - Write at adr 0x8 with lane 2 of wb_dat_o = 0x0000002A -> one-cycle r_valid, r_data=0x2A, r_adr=0x8, level unchanged.
  - Push 9 words with DEPTH=8 -> s_ready low after the 8th, 9th dropped, 8 reads return the words in push order.
  - WAIT_ST=3, rst_n low on the 2nd wait cycle -> no ack, level=0, FSM IDLE, underrun=0.
  - GUVM_WB_ERR_INJ_EN defined, push with s_err=1, then read -> one-cycle wb_err, wb_ack=0, wb_dat_i=0.
